// File: rtl/imuldiv_int_div_iterative_param.sv
// Iterative restoring divider, W-bit operands, signed or unsigned, that
// resolves BITS_PER_CYCLE quotient bits per cycle. It uses a val/rdy request
// and response handshake and reports divide-by-zero explicitly.
// Response layout is {remainder, quotient}.

`ifndef IMULDIV_DIVREQ_MSG_FUNC_SIGNED
`define IMULDIV_DIVREQ_MSG_FUNC_SIGNED 1'b0
`endif
`ifndef IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED
`define IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED 1'b1
`endif

module imuldiv_int_div_iterative_param #(
    parameter int W              = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           divreq_msg_fn,
    input  logic [W-1:0]   divreq_msg_a,
    input  logic [W-1:0]   divreq_msg_b,
    input  logic           divreq_val,
    output logic           divreq_rdy,
    output logic [2*W-1:0] divresp_msg_result,
    output logic           divresp_msg_divzero,
    output logic           divresp_val,
    input  logic           divresp_rdy
);

    localparam int STEPS = W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Sign bits are stored already qualified by signed mode, so the
    // function select itself is not needed after the accepting edge.
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [W-1:0]     a_raw_q, a_raw_d;
    logic [W-1:0]     div_q, div_d;
    logic             dz_q, dz_d;
    // {partial remainder, quotient}. The partial remainder is always below
    // the divisor between steps, so the top bit of the (2W+1)-bit working
    // window is always zero here and only exists inside each step.
    logic [2*W-1:0]   rq_q, rq_d;
    logic [2*W-1:0]   res_q, res_d;
    logic             res_dz_q, res_dz_d;

    logic             req_signed;
    logic             a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;
    logic [W-1:0]     q_mag, r_mag, q_fin, r_fin;

    // Chain of restoring steps evaluated within one CALC cycle.
    logic [2*W-1:0]   stage [0:BITS_PER_CYCLE];

    assign stage[0] = rq_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [2*W:0] sh;
            logic [W:0]   trial;
            assign sh    = {stage[gi], 1'b0};
            assign trial = sh[2*W:W] - {1'b0, div_q};
            assign stage[gi+1] = trial[W] ? sh[2*W-1:0]
                                          : {trial[W-1:0], sh[W-1:1], 1'b1};
        end
    endgenerate

    // Operand magnitudes: negate only negative operands in signed mode.
    assign req_signed = (divreq_msg_fn == `IMULDIV_DIVREQ_MSG_FUNC_SIGNED);
    assign a_neg      = req_signed && divreq_msg_a[W-1];
    assign b_neg      = req_signed && divreq_msg_b[W-1];
    assign a_mag      = a_neg ? -divreq_msg_a : divreq_msg_a;
    assign b_mag      = b_neg ? -divreq_msg_b : divreq_msg_b;

    // Sign fix-up of the final step output; MIN / -1 wraps back to MIN
    // naturally, so no overflow special case is needed.
    assign q_mag = stage[BITS_PER_CYCLE][W-1:0];
    assign r_mag = stage[BITS_PER_CYCLE][2*W-1:W];
    assign q_fin = dz_q ? {W{1'b1}} : ((sign_a_q ^ sign_b_q) ? -q_mag : q_mag);
    assign r_fin = dz_q ? a_raw_q   : (sign_a_q ? -r_mag : r_mag);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_raw_q  <= '0;
            div_q    <= '0;
            dz_q     <= 1'b0;
            rq_q     <= '0;
            res_q    <= '0;
            res_dz_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_raw_q  <= a_raw_d;
            div_q    <= div_d;
            dz_q     <= dz_d;
            rq_q     <= rq_d;
            res_q    <= res_d;
            res_dz_q <= res_dz_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        a_raw_d     = a_raw_q;
        div_d       = div_q;
        dz_d        = dz_q;
        rq_d        = rq_q;
        res_d       = res_q;
        res_dz_d    = res_dz_q;
        divreq_rdy  = 1'b0;
        divresp_val = 1'b0;

        case (state_q)
            IDLE: begin
                divreq_rdy = 1'b1;
                if (divreq_val) begin
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    a_raw_d  = divreq_msg_a;
                    div_d    = b_mag;
                    dz_d     = (divreq_msg_b == '0);
                    rq_d     = {{W{1'b0}}, a_mag};
                    cnt_d    = CNT_INIT;
                    state_d  = CALC;
                end
            end
            CALC: begin
                rq_d  = stage[BITS_PER_CYCLE];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_d    = {r_fin, q_fin};
                    res_dz_d = dz_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                divresp_val = 1'b1;
                if (divresp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign divresp_msg_result  = res_q;
    assign divresp_msg_divzero = res_dz_q;

endmodule

// File: tb/tb_imuldiv_int_div_iterative_param.sv
// Directed bench for the iterative divider: a 32-bit/1-bit-per-cycle
// instance for the main cases and a 16-bit/4-bits-per-cycle instance.
module tb_imuldiv_int_div_iterative_param;

    // PARC function encoding.
    localparam logic FN_SIGNED   = 1'b0;
    localparam logic FN_UNSIGNED = 1'b1;

    logic        clk;
    logic        reset;

    logic        fn, val, rdy, resp_val, resp_rdy, dz;
    logic [31:0] a, b;
    logic [63:0] res;

    logic        fn_h, val_h, rdy_h, resp_val_h, resp_rdy_h, dz_h;
    logic [15:0] a_h, b_h;
    logic [31:0] res_h;

    int checks = 0;
    int errors = 0;

    imuldiv_int_div_iterative_param #(.W(32), .BITS_PER_CYCLE(1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .divreq_msg_fn       (fn),
        .divreq_msg_a        (a),
        .divreq_msg_b        (b),
        .divreq_val          (val),
        .divreq_rdy          (rdy),
        .divresp_msg_result  (res),
        .divresp_msg_divzero (dz),
        .divresp_val         (resp_val),
        .divresp_rdy         (resp_rdy)
    );

    imuldiv_int_div_iterative_param #(.W(16), .BITS_PER_CYCLE(4)) dut_h (
        .clk                 (clk),
        .reset               (reset),
        .divreq_msg_fn       (fn_h),
        .divreq_msg_a        (a_h),
        .divreq_msg_b        (b_h),
        .divreq_val          (val_h),
        .divreq_rdy          (rdy_h),
        .divresp_msg_result  (res_h),
        .divresp_msg_divzero (dz_h),
        .divresp_val         (resp_val_h),
        .divresp_rdy         (resp_rdy_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One full 32-bit transaction with the response consumed immediately.
    task automatic run_op(input string tag, input logic f, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [63:0] exp_res,
                          input logic exp_dz);
        int cyc;
        @(negedge clk);
        fn  = f;
        a   = ia;
        b   = ib;
        val = 1'b1;
        cyc = 0;
        while (!rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_req_rdy"}, 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; they must not matter.
        val = 1'b0;
        a   = ~ia;
        b   = ib + 32'd1;
        fn  = ~f;
        cyc = 0;
        while (!resp_val && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd32);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_divzero"}, 64'(dz), 64'(exp_dz));
        $display("txn %s a=%h b=%h fn=%0d result=%h divzero=%0d", tag, ia, ib, f, res, dz);
        @(posedge clk);
        #1;
        check({tag, "_resp_drop"}, 64'(resp_val), 64'd0);
    endtask

    task automatic run_op16(input string tag, input logic f, input logic [15:0] ia,
                            input logic [15:0] ib, input logic [31:0] exp_res);
        int cyc;
        @(negedge clk);
        fn_h  = f;
        a_h   = ia;
        b_h   = ib;
        val_h = 1'b1;
        check({tag, "_req_rdy"}, 64'(rdy_h), 64'd1);
        @(posedge clk);
        #1;
        val_h = 1'b0;
        cyc   = 0;
        while (!resp_val_h && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd4);
        check({tag, "_result"}, 64'(res_h), 64'(exp_res));
        check({tag, "_divzero"}, 64'(dz_h), 64'd0);
        $display("txn %s a=%h b=%h fn=%0d result=%h", tag, ia, ib, f, res_h);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        logic seen;

        reset = 1'b0;
        fn = FN_UNSIGNED; a = '0; b = '0; val = 1'b0; resp_rdy = 1'b1;
        fn_h = FN_UNSIGNED; a_h = '0; b_h = '0; val_h = 1'b0; resp_rdy_h = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_rdy",  64'(rdy), 64'd1);
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_result",   res, 64'd0);
        check("rst_divzero",  64'(dz), 64'd0);
        reset = 1'b1;

        run_op("u_100_7",    FN_UNSIGNED, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0);
        run_op("s_m7_2",     FN_SIGNED,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("s_7_m2",     FN_SIGNED,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
        run_op("s_m7_m2",    FN_SIGNED,   32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0);
        run_op("u_m7_2",     FN_UNSIGNED, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, 1'b0);
        run_op("s_min_m1",   FN_SIGNED,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        run_op("u_max_1",    FN_UNSIGNED, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 1'b0);
        run_op("u_max_msb",  FN_UNSIGNED, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, 1'b0);
        run_op("u_5_0",      FN_UNSIGNED, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1);
        run_op("s_m5_0",     FN_SIGNED,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1'b1);

        // Response back-pressure with a competing request held pending.
        resp_rdy = 1'b0;
        @(negedge clk);
        fn = FN_UNSIGNED; a = 32'd100; b = 32'd7; val = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd50; b = 32'd5;
        cyc = 0;
        while (!resp_val && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'd32);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result",  res, 64'h00000002_0000000E);
            check("bp_hold_val",     64'(resp_val), 64'd1);
            check("bp_hold_req_rdy", 64'(rdy), 64'd0);
        end
        $display("txn bp_100_7 held result=%h for 10 cycles", res);
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_req_rdy",  64'(rdy), 64'd1);
        check("bp_idle_resp_val", 64'(resp_val), 64'd0);
        @(posedge clk);
        #1;
        check("bp_accept", 64'(rdy), 64'd0);
        val = 1'b0;
        cyc = 0;
        while (!resp_val && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp2_latency", 64'(cyc), 64'd32);
        check("bp2_result",  res, 64'h00000000_0000000A);
        $display("txn bp_50_5 result=%h", res);
        @(posedge clk);
        #1;

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        fn = FN_UNSIGNED; a = 32'd1000; b = 32'd3; val = 1'b1;
        @(posedge clk);
        #1;
        val = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_resp_val", 64'(resp_val), 64'd0);
        check("abort_req_rdy",  64'(rdy), 64'd1);
        check("abort_result",   res, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_val) seen = 1'b1;
        end
        check("abort_no_resp", 64'(seen), 64'd0);
        $display("txn abort_1000_3 response_seen=%0d", seen);

        run_op16("h_u_1000_3",  FN_UNSIGNED, 16'd1000,  16'd3, {16'd1, 16'd333});
        run_op16("h_s_m1000_3", FN_SIGNED,   16'hFC18,  16'd3, {16'hFFFF, 16'hFEB3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imuldiv_int_div_iterative_param.md
Name: imuldiv_int_div_iterative_param

Overview:
Parametrised iterative restoring divider, successor to the fixed 32-bit iterative div unit. It computes the quotient and remainder of W-bit operands, signed or unsigned, retiring BITS_PER_CYCLE quotient bits per cycle. It has explicit divide-by-zero handling and a val/rdy request/response interface. It sits behind the muldiv request arbiter in the PARC pipeline's muldiv unit.

Parameters:
W, 32, operand width in bits; must be even and at least 4.
BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; must divide W (legal values 1, 2, 4).

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
divreq_msg_fn  input  1  operation select, encoded as `IMULDIV_DIVREQ_MSG_FUNC_SIGNED / `IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED
divreq_msg_a  input  W  dividend
divreq_msg_b  input  W  divisor
divreq_val  input  1  request valid
divreq_rdy  output  1  request ready
divresp_msg_result  output  2W  {remainder, quotient}; remainder in the upper W bits
divresp_msg_divzero  output  1  set when the divisor of this response was zero
divresp_val  output  1  response valid
divresp_rdy  input  1  response ready

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, step counter=0.
  - divresp_val=0, divreq_rdy=1 (combinational from IDLE), divresp_msg_result=0, divresp_msg_divzero=0.
  - Reset asserted mid-operation aborts the division; the operation is lost, no response is issued.
- FSM states: IDLE, CALC, DONE.
  - IDLE: divreq_rdy=1. On divreq_val && divreq_rdy at edge t0:
    - Latch fn and the operand sign bits.
    - Load the remainder/quotient register as {(W+1)'b0, |a|}.
    - Latch divisor |b|.
    - Set counter = W/BITS_PER_CYCLE.
    - divzero_reg = (b==0).
    - Go to CALC.
    - Magnitude is taken only when fn is SIGNED and the sign bit is 1 (two's complement negate); otherwise the operand is used raw.
  - CALC: divreq_rdy=0.
    - Each cycle performs BITS_PER_CYCLE restoring steps. Per step: shift the 2W+1-bit register left by 1; trial = upper (W+1) bits - {1'b0, divisor}; if trial is non-negative, write back trial and set the quotient LSB to 1; else restore and set the LSB to 0.
    - Counter decrements once per cycle. The cycle in which counter==1 finishes the last steps; its edge loads the output registers and goes to DONE.
  - Output fix-up, registered on entry to DONE:
    - Divide by zero: quotient = all ones; remainder = original divreq_msg_a (unmodified, either mode); divresp_msg_divzero=1.
    - Otherwise, signed mode: negate quotient if sign_a^sign_b; negate remainder if sign_a.
    - Overflow case (signed MIN / -1) needs no special path: quotient=MIN, remainder=0.
  - DONE: divresp_val=1 and divreq_rdy=0. Result and divzero are held stable until divresp_val && divresp_rdy; on that edge go to IDLE.
  - No new request is accepted in the DONE cycle, even if the response is consumed in the same cycle.
- Latency:
  - divresp_val rises exactly W/BITS_PER_CYCLE cycles after the accepting edge t0 (32 cycles for defaults).
  - Minimum initiation interval is W/BITS_PER_CYCLE + 2 cycles.
- Inputs are sampled only at the accepting edge; operand changes afterwards have no effect.
- divresp_rdy held high on entry to DONE gives a one-cycle DONE.
- Widths: internal arithmetic is W+1 bits, so there is no truncation at W-bit MSB divisors.

Test Plan:
- Unsigned 100/7, W=32, BPC=1 -> result 64'h00000002_0000000E, divzero=0; divresp_val high exactly 32 cycles after accept.
- Signed -7/2 (a=32'hFFFFFFF9, b=2) -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. Signed 7/-2 -> quotient 32'hFFFFFFFD, remainder 32'h00000001.
- Signed 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0. Unsigned 32'hFFFFFFFF/1 -> quotient 32'hFFFFFFFF, remainder 0.
- Unsigned 5/0 -> quotient 32'hFFFFFFFF, remainder 5, divzero=1. Signed -5/0 -> quotient 32'hFFFFFFFF, remainder 32'hFFFFFFFB, divzero=1.
- divresp_rdy low for 10 cycles after DONE -> result held constant, divreq_rdy=0 and a pending divreq_val is not accepted. After the response handshake, the request is accepted 1 cycle later from IDLE.
- reset driven low at CALC cycle 10, between edges -> divresp_val=0 and divreq_rdy=1 immediately, with no response afterwards. Variant W=16, BPC=4, unsigned 1000/3 -> result {16'd1, 16'd333} after 4 cycles.
